// File: rtl/fm_serial_pkg.sv
// fm_serial_pkg
//   Shared types and helpers for the FM radio PCM output serializer.
//   - ser_state_t : serializer FSM states
//   - BYTE_W      : width of one output byte
//   - sat_trunc   : signed clamp to a two's-complement range of 'bits' bits,
//                   present only when SERIALIZER_SATURATE_EN is defined
//   Build option: SERIALIZER_SATURATE_EN (saturating quantisation).
package fm_serial_pkg;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_SEND = 1'b1
  } ser_state_t;

  localparam int BYTE_W = 8;

`ifdef SERIALIZER_SATURATE_EN
  // Clamp value into [-2^(bits-1), 2^(bits-1)-1]; caller truncates to 'bits'.
  function automatic logic signed [63:0] sat_trunc(input logic signed [63:0] value,
                                                   input int bits);
    logic signed [63:0] max_v;
    logic signed [63:0] min_v;
    logic signed [63:0] res;
    max_v = (64'sd1 <<< (bits - 1)) - 64'sd1;
    min_v = -(64'sd1 <<< (bits - 1));
    if (value > max_v) begin
      res = max_v;
    end else if (value < min_v) begin
      res = min_v;
    end else begin
      res = value;
    end
    return res;
  endfunction
`endif

endpackage

// File: rtl/sample_quantize.sv
// sample_quantize
//   Combinational scaler: arithmetic right shift by SHIFT, then reduction of the
//   signed result to OUT_BITS bits, either clamped (SERIALIZER_SATURATE_EN
//   defined) or wrapped by plain truncation (default).
//   Ports:
//     sample  in   IN_WIDTH  signed input sample
//     quant   out  OUT_BITS  quantised PCM word
module sample_quantize
  import fm_serial_pkg::*;
#(
  parameter int IN_WIDTH = 32,
  parameter int SHIFT    = 0,
  parameter int OUT_BITS = 16
) (
  input  logic signed [IN_WIDTH-1:0] sample,
  output logic        [OUT_BITS-1:0] quant
);

  logic signed [IN_WIDTH-1:0] shifted_s;

  // Sign-preserving scale followed by width reduction.
  always_comb begin
    shifted_s = sample >>> SHIFT;
`ifdef SERIALIZER_SATURATE_EN
    quant = OUT_BITS'(sat_trunc(64'(shifted_s), OUT_BITS));
`else
    quant = OUT_BITS'(shifted_s);
`endif
  end

endmodule

// File: rtl/sample_byte_serializer.sv
// sample_byte_serializer
//   Output end of the FM radio pipeline. Pops signed samples from an upstream
//   FWFT FIFO, quantises them to OUT_BYTES*8-bit PCM and pushes them LSB first
//   into a downstream byte FIFO. Back-to-back samples stream with no gap.
//   Build option: SERIALIZER_SATURATE_EN selects clamping instead of wrap.
//   Ports:
//     clock      in   1         rising-edge clock
//     reset      in   1         synchronous, active-high
//     in_rd_en   out  1         pop upstream FIFO
//     in_empty   in   1         upstream FIFO empty
//     in_dout    in   IN_WIDTH  upstream head sample (valid while !in_empty)
//     out_wr_en  out  1         push downstream byte FIFO
//     out_full   in   1         downstream FIFO full
//     out_din    out  8         byte being pushed
//     busy       out  1         a sample is held and not yet fully sent
module sample_byte_serializer
  import fm_serial_pkg::*;
#(
  parameter int IN_WIDTH  = 32,
  parameter int SHIFT     = 0,
  parameter int OUT_BYTES = 2
) (
  input  logic                clock,
  input  logic                reset,
  output logic                in_rd_en,
  input  logic                in_empty,
  input  logic [IN_WIDTH-1:0] in_dout,
  output logic                out_wr_en,
  input  logic                out_full,
  output logic [7:0]          out_din,
  output logic                busy
);

  localparam int         OUT_BITS = BYTE_W * OUT_BYTES;
  localparam logic [1:0] LAST_CNT = 2'(OUT_BYTES - 1);

  ser_state_t          state_r;
  ser_state_t          state_nxt_s;
  logic [1:0]          byte_cnt_r;
  logic [1:0]          byte_cnt_nxt_s;
  logic [OUT_BITS-1:0] sreg_r;
  logic [OUT_BITS-1:0] sreg_nxt_s;
  logic [OUT_BITS-1:0] quant_s;
  // Set by reset; keeps the FIFO un-popped for the first cycle after reset.
  logic                hold_r;
  logic                pop_s;
  logic                push_s;
  logic                busy_s;

  sample_quantize #(
    .IN_WIDTH (IN_WIDTH),
    .SHIFT    (SHIFT),
    .OUT_BITS (OUT_BITS)
  ) u_quant (
    .sample (in_dout),
    .quant  (quant_s)
  );

  // Next-state, pop/push decode and shift-register update.
  always_comb begin
    state_nxt_s    = state_r;
    byte_cnt_nxt_s = byte_cnt_r;
    sreg_nxt_s     = sreg_r;
    pop_s          = 1'b0;
    push_s         = 1'b0;
    busy_s         = 1'b0;
    if (reset) begin
      state_nxt_s = S_IDLE;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (!in_empty && !hold_r) begin
            pop_s          = 1'b1;
            sreg_nxt_s     = quant_s;
            byte_cnt_nxt_s = 2'd0;
            state_nxt_s    = S_SEND;
          end else begin
            state_nxt_s = S_IDLE;
          end
        end
        S_SEND: begin
          busy_s = 1'b1;
          if (!out_full) begin
            push_s = 1'b1;
            if (byte_cnt_r == LAST_CNT) begin
              // Last byte leaves this cycle: chain straight into the next
              // sample if one is waiting, so the byte stream has no bubble.
              byte_cnt_nxt_s = 2'd0;
              if (!in_empty) begin
                pop_s      = 1'b1;
                sreg_nxt_s = quant_s;
              end else begin
                sreg_nxt_s  = sreg_r >> BYTE_W;
                state_nxt_s = S_IDLE;
              end
            end else begin
              sreg_nxt_s     = sreg_r >> BYTE_W;
              byte_cnt_nxt_s = byte_cnt_r + 2'd1;
            end
          end else begin
            // Downstream full: hold the current byte in place.
            push_s = 1'b0;
          end
        end
        default: begin
          state_nxt_s = S_IDLE;
        end
      endcase
    end
  end

  // Output drive; everything is forced quiet while reset is asserted.
  always_comb begin
    in_rd_en  = pop_s;
    out_wr_en = push_s;
    busy      = busy_s;
    if (reset) begin
      out_din = 8'd0;
    end else begin
      out_din = sreg_r[7:0];
    end
  end

  // State, byte counter, shift register and post-reset pop hold.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r    <= S_IDLE;
      byte_cnt_r <= 2'd0;
      sreg_r     <= '0;
      hold_r     <= 1'b1;
    end else begin
      state_r    <= state_nxt_s;
      byte_cnt_r <= byte_cnt_nxt_s;
      sreg_r     <= sreg_nxt_s;
      hold_r     <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sample_byte_serializer.sv
// tb_sample_byte_serializer
//   Directed bench for sample_byte_serializer. Two instances run in lockstep
//   on the same upstream FIFO model: SHIFT=0 and SHIFT=4 (both OUT_BYTES=2).
//   Inputs change on the falling edge; outputs are sampled 3-4 time units
//   later, well away from the rising edge.
module tb_sample_byte_serializer;

  logic        clock;
  logic        reset;
  logic        in_empty;
  logic [31:0] in_dout;
  logic        out_full;
  logic        in_rd_en, out_wr_en, busy;
  logic [7:0]  out_din;
  logic        in_rd_en_4, out_wr_en_4, busy_4;
  logic [7:0]  out_din_4;

  logic [31:0] fifo[$];
  logic [7:0]  out_q[$];
  logic [7:0]  out_q4[$];

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [31:0] sample;
    logic [7:0]  b0;
    logic [7:0]  b1;
    logic [7:0]  s4b0;
    logic [7:0]  s4b1;
  } vec_t;

  vec_t vecs[8];

  sample_byte_serializer #(.IN_WIDTH(32), .SHIFT(0), .OUT_BYTES(2)) dut (
    .clock     (clock),
    .reset     (reset),
    .in_rd_en  (in_rd_en),
    .in_empty  (in_empty),
    .in_dout   (in_dout),
    .out_wr_en (out_wr_en),
    .out_full  (out_full),
    .out_din   (out_din),
    .busy      (busy)
  );

  sample_byte_serializer #(.IN_WIDTH(32), .SHIFT(4), .OUT_BYTES(2)) dut_s4 (
    .clock     (clock),
    .reset     (reset),
    .in_rd_en  (in_rd_en_4),
    .in_empty  (in_empty),
    .in_dout   (in_dout),
    .out_wr_en (out_wr_en_4),
    .out_full  (out_full),
    .out_din   (out_din_4),
    .busy      (busy_4)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // FIFO models: refresh the FWFT head, then act on the settled strobes.
  always begin
    @(negedge clock);
    #2;
    in_empty = (fifo.size() == 0);
    in_dout  = (fifo.size() == 0) ? 32'h0 : fifo[0];
    #1;
    if (in_rd_en === 1'b1 && fifo.size() > 0) void'(fifo.pop_front());
    if (out_wr_en === 1'b1) out_q.push_back(out_din);
    if (out_wr_en_4 === 1'b1) out_q4.push_back(out_din_4);
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clock);
  endtask

  task automatic look();
    #4;
  endtask

  function automatic logic [31:0] qget(input int which, input int k);
    if (which == 0) return (out_q.size() > k) ? {24'h0, out_q[k]} : 32'hDEAD_0000;
    else return (out_q4.size() > k) ? {24'h0, out_q4[k]} : 32'hDEAD_0000;
  endfunction

  task automatic drain(input int nbytes, input int budget);
    for (int c = 0; c < budget; c++) begin
      if (out_q.size() >= nbytes && busy === 1'b0 && fifo.size() == 0) break;
      tick();
      look();
    end
  endtask

  initial begin
    int first_pop, first_wr, last_wr, nwr, nbad;
    logic [15:0] h;
    logic [31:0] s;
    logic [31:0] golden[$];

    vecs[0] = '{32'h0000_1234, 8'h34, 8'h12, 8'h23, 8'h01};
    vecs[1] = '{32'hFFFF_FFFE, 8'hFE, 8'hFF, 8'hFF, 8'hFF};
    vecs[5] = '{32'h0000_7FFF, 8'hFF, 8'h7F, 8'hFF, 8'h07};
    vecs[6] = '{32'hFFFF_8000, 8'h00, 8'h80, 8'h00, 8'hF8};
`ifdef SERIALIZER_SATURATE_EN
    vecs[2] = '{32'h0000_9C40, 8'hFF, 8'h7F, 8'hC4, 8'h09};
    vecs[3] = '{32'hFFFF_63C0, 8'h00, 8'h80, 8'h3C, 8'hF6};
    vecs[4] = '{32'h0001_2340, 8'hFF, 8'h7F, 8'h34, 8'h12};
    vecs[7] = '{32'h8000_0000, 8'h00, 8'h80, 8'h00, 8'h80};
`else
    vecs[2] = '{32'h0000_9C40, 8'h40, 8'h9C, 8'hC4, 8'h09};
    vecs[3] = '{32'hFFFF_63C0, 8'hC0, 8'h63, 8'h3C, 8'hF6};
    vecs[4] = '{32'h0001_2340, 8'h40, 8'h23, 8'h34, 8'h12};
    vecs[7] = '{32'h8000_0000, 8'h00, 8'h00, 8'h00, 8'h00};
`endif

    // Reset state, during reset and the cycle after.
    reset = 1'b1;
    out_full = 1'b0;
    tick(); look();
    check("reset outputs", {21'h0, in_rd_en, out_wr_en, busy, out_din},
          32'h0);
    tick(); reset = 1'b0; look();
    check("post-reset outputs", {21'h0, in_rd_en, out_wr_en, busy, out_din},
          32'h0);
    tick(); look();
    tick(); look();

    // Latency and busy profile of a single sample.
    tick(); fifo.push_back(32'h0000_1234); look();
    check("t0 pop", {21'h0, in_rd_en, out_wr_en, busy, 8'h00}, {21'h0, 3'b100, 8'h00});
    tick(); look();
    check("t1 byte0", {21'h0, in_rd_en, out_wr_en, busy, out_din}, {21'h0, 3'b011, 8'h34});
    tick(); look();
    check("t2 byte1", {21'h0, in_rd_en, out_wr_en, busy, out_din}, {21'h0, 3'b011, 8'h12});
    tick(); look();
    check("t3 idle", {21'h0, in_rd_en, out_wr_en, busy}, 32'h0);
    tick(); look();

    // Table of quantisation vectors.
    for (int i = 0; i < 8; i++) begin
      out_q.delete();
      out_q4.delete();
      tick(); fifo.push_back(vecs[i].sample); look();
      drain(2, 20);
      check($sformatf("vec%0d count", i), out_q.size(), 2);
      check($sformatf("vec%0d byte0", i), qget(0, 0), {24'h0, vecs[i].b0});
      check($sformatf("vec%0d byte1", i), qget(0, 1), {24'h0, vecs[i].b1});
      check($sformatf("vec%0d s4 byte0", i), qget(1, 0), {24'h0, vecs[i].s4b0});
      check($sformatf("vec%0d s4 byte1", i), qget(1, 1), {24'h0, vecs[i].s4b1});
      tick(); look();
    end

    // Downstream stall between byte 0 and byte 1.
    out_q.delete();
    tick(); fifo.push_back(32'h0000_3EEF); look();
    tick(); look();
    for (int k = 0; k < 5; k++) begin
      tick();
      if (k == 0) begin
        out_full = 1'b1;
        fifo.push_back(32'h0000_1357);
      end
      look();
      check($sformatf("stall cycle %0d", k), {21'h0, in_rd_en, out_wr_en, busy, out_din},
            {21'h0, 3'b001, 8'h3E});
    end
    tick(); out_full = 1'b0; look();
    check("stall release", {21'h0, in_rd_en, out_wr_en, busy, out_din}, {21'h0, 3'b111, 8'h3E});
    drain(4, 20);
    check("stall count", out_q.size(), 4);
    check("stall stream", {qget(0, 0)[7:0], qget(0, 1)[7:0], qget(0, 2)[7:0], qget(0, 3)[7:0]},
          32'hEF3E_5713);
    tick(); look();

    // 256 preloaded samples streamed without a stall.
    out_q.delete();
    golden.delete();
    first_pop = -1; first_wr = -1; last_wr = -1; nwr = 0;
    tick();
    for (int i = 0; i < 256; i++) begin
      h = 16'(i * 257) ^ 16'h5A3C;
      s = {{16{h[15]}}, h};
      fifo.push_back(s);
      golden.push_back(s);
    end
    look();
    for (int c = 0; c < 560; c++) begin
      if (in_rd_en === 1'b1 && first_pop < 0) first_pop = c;
      if (out_wr_en === 1'b1) begin
        if (first_wr < 0) first_wr = c;
        last_wr = c;
        nwr++;
      end
      tick(); look();
    end
    check("stream writes", nwr, 512);
    check("stream span", last_wr - first_pop, 512);
    check("stream continuous", last_wr - first_wr, 511);
    nbad = 0;
    for (int i = 0; i < 256; i++) begin
      if (qget(0, 2 * i) !== {24'h0, golden[i][7:0]} ||
          qget(0, 2 * i + 1) !== {24'h0, golden[i][15:8]}) nbad++;
    end
    check("stream bytes", nbad, 0);

    // Reset in the middle of sample A.
    out_q.delete();
    tick(); fifo.push_back(32'h0000_2B12); look();
    tick(); look();
    tick(); reset = 1'b1; fifo.push_back(32'h0000_34CD); look();
    check("mid reset outputs", {21'h0, in_rd_en, out_wr_en, busy, out_din}, 32'h0);
    tick(); reset = 1'b0; look();
    drain(3, 20);
    check("mid reset count", out_q.size(), 3);
    check("mid reset stream", {8'h0, qget(0, 0)[7:0], qget(0, 1)[7:0], qget(0, 2)[7:0]},
          32'h0012_CD34);

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
